// File: rtl/aha_counter_bank.sv
// Bank of NUM_CH independent WIDTH-bit event counters with clear/load/wrap/saturate and overflow flags.
// Optional coherent snapshot of all channels when AHA_COUNTER_SNAPSHOT_EN is defined.
module aha_counter_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [NUM_CH-1:0]         EN,
    input  logic [NUM_CH-1:0]         CLR,
    input  logic [NUM_CH-1:0]         LOAD,
    input  logic [NUM_CH*WIDTH-1:0]   LOAD_VAL,
    input  logic [NUM_CH-1:0]         SAT_MODE,
    input  logic [NUM_CH-1:0]         OVF_CLR,
`ifdef AHA_COUNTER_SNAPSHOT_EN
    input  logic                      SNAP,
    output logic [NUM_CH*WIDTH-1:0]   SNAP_Q,
`endif
    output logic [NUM_CH*WIDTH-1:0]   Q,
    output logic [NUM_CH-1:0]         OVF,
    output logic [NUM_CH-1:0]         OVF_STICKY
);

    localparam int unsigned BUS_W = NUM_CH * WIDTH;
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [BUS_W-1:0]  q_r, q_nxt;
    logic [NUM_CH-1:0] ovf_r, ovf_nxt;
    logic [NUM_CH-1:0] sticky_r, sticky_nxt;

    // Per-channel next state, priority CLR > LOAD > EN > hold; overflow set beats OVF_CLR.
    always_comb begin
        q_nxt      = q_r;
        ovf_nxt    = '0;
        sticky_nxt = sticky_r;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (CLR[i]) begin
                q_nxt[i*WIDTH +: WIDTH] = '0;
                sticky_nxt[i]           = 1'b0;
            end else begin
                if (OVF_CLR[i]) begin
                    sticky_nxt[i] = 1'b0;
                end
                if (LOAD[i]) begin
                    q_nxt[i*WIDTH +: WIDTH] = LOAD_VAL[i*WIDTH +: WIDTH];
                end else if (EN[i]) begin
                    if (q_r[i*WIDTH +: WIDTH] == MAX) begin
                        q_nxt[i*WIDTH +: WIDTH] = SAT_MODE[i] ? MAX : '0;
                        ovf_nxt[i]              = 1'b1;
                        sticky_nxt[i]           = 1'b1;
                    end else begin
                        q_nxt[i*WIDTH +: WIDTH] = q_r[i*WIDTH +: WIDTH] + WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            q_r      <= '0;
            ovf_r    <= '0;
            sticky_r <= '0;
        end else begin
            q_r      <= q_nxt;
            ovf_r    <= ovf_nxt;
            sticky_r <= sticky_nxt;
        end
    end

    assign Q          = q_r;
    assign OVF        = ovf_r;
    assign OVF_STICKY = sticky_r;

`ifdef AHA_COUNTER_SNAPSHOT_EN
    logic [BUS_W-1:0] snap_r;

    // Captures the pre-update counts so software sees one coherent set.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            snap_r <= '0;
        end else if (SNAP) begin
            snap_r <= q_r;
        end
    end

    assign SNAP_Q = snap_r;
`endif

endmodule
